// File: rtl/timed_event_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : timed_event_queue_if                                            |
// | Purpose  : Write, flush, time and fire/late bus of the timed event queue.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
interface timed_event_queue_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 128
);
  logic                  flush;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [63:0]           counter;
  logic                  full;
  logic                  empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  counter_matched;
  logic [DATA_WIDTH-1:0] gpo_in;
  logic                  late_error;
  logic [DATA_WIDTH-1:0] late_data;

  modport master (
    output flush, wr_en, wr_data, counter,
    input  full, empty, count, overflow, counter_matched, gpo_in, late_error, late_data
  );

  modport slave (
    input  flush, wr_en, wr_data, counter,
    output full, empty, count, overflow, counter_matched, gpo_in, late_error, late_data
  );
endinterface
`default_nettype wire

// File: rtl/timed_event_queue.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : timed_event_queue                                               |
// | Purpose  : Timestamp-scheduled instruction queue feeding a GPO core; fires |
// |            the head when its timestamp equals the system counter.          |
// | Option   : TIMED_EVENT_QUEUE_LATE_FIRE_EN - still emit late heads.         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module timed_event_queue #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 128
) (
  input  logic              CLK100MHZ,
  input  logic              reset,
  timed_event_queue_if.slave bus
);
  localparam int                  DEPTH     = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ARMED = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  overflow_q, overflow_d;
  logic                  matched_q, matched_d;
  logic                  late_q, late_d;
  logic [DATA_WIDTH-1:0] gpo_q, gpo_d;
  logic [DATA_WIDTH-1:0] late_data_q, late_data_d;
  logic [DATA_WIDTH-1:0] head_q;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  wr_ok;
  logic                  pop;
  logic                  ram_nonempty;
  logic [63:0]           head_ts;

  assign wr_ok        = bus.wr_en && !full_q && !bus.flush;
  assign ram_nonempty = (wr_ptr_q != rd_ptr_q);
  assign head_ts      = head_q[DATA_WIDTH-1 -: 64];

  assign bus.full            = full_q;
  assign bus.empty           = empty_q;
  assign bus.count           = count_q;
  assign bus.overflow        = overflow_q;
  assign bus.counter_matched = matched_q;
  assign bus.gpo_in          = gpo_q;
  assign bus.late_error      = late_q;
  assign bus.late_data       = late_data_q;

  always_comb begin
    state_d     = state_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q + (ADDR_WIDTH+1)'(wr_ok);
    pop         = 1'b0;
    overflow_d  = bus.wr_en && full_q && !bus.flush;
    matched_d   = 1'b0;
    late_d      = 1'b0;
    gpo_d       = gpo_q;
    late_data_d = late_data_q;

    case (state_q)
      IDLE: begin
        if (ram_nonempty) state_d = FETCH;
      end
      FETCH: begin
        rd_ptr_d = rd_ptr_q + 1'b1;
        state_d  = ARMED;
      end
      ARMED: begin
        if (head_ts == bus.counter) begin
          pop       = 1'b1;
          matched_d = 1'b1;
          gpo_d     = head_q;
        end else if (head_ts < bus.counter) begin
          pop         = 1'b1;
          late_d      = 1'b1;
          late_data_d = head_q;
`ifdef TIMED_EVENT_QUEUE_LATE_FIRE_EN
          matched_d   = 1'b1;
          gpo_d       = head_q;
`endif
        end
        if (pop) state_d = ram_nonempty ? FETCH : IDLE;
      end
      default: state_d = IDLE;
    endcase

    count_d = count_q + (ADDR_WIDTH+1)'(wr_ok) - (ADDR_WIDTH+1)'(pop);

    // Flush drops everything queued but keeps the last fired/late entries visible.
    if (bus.flush) begin
      state_d     = IDLE;
      rd_ptr_d    = '0;
      wr_ptr_d    = '0;
      count_d     = '0;
      overflow_d  = 1'b0;
      matched_d   = 1'b0;
      late_d      = 1'b0;
      gpo_d       = gpo_q;
      late_data_d = late_data_q;
    end

    full_d  = (count_d == DEPTH_CNT);
    empty_d = (count_d == '0);
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      overflow_q  <= 1'b0;
      matched_q   <= 1'b0;
      late_q      <= 1'b0;
      gpo_q       <= '0;
      late_data_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      overflow_q  <= overflow_d;
      matched_q   <= matched_d;
      late_q      <= late_d;
      gpo_q       <= gpo_d;
      late_data_q <= late_data_d;
    end
  end

  // Storage has no reset; the head register doubles as the RAM's registered read port.
  always_ff @(posedge CLK100MHZ) begin
    if (wr_ok) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= bus.wr_data;
    if (state_q == FETCH) head_q <= mem_q[rd_ptr_q[ADDR_WIDTH-1:0]];
  end
endmodule
`default_nettype wire
